// File: rtl/mod_exponentiator.sv
// mod_exponentiator: result = base^exp mod modulus.
// Left-to-right square-and-multiply. Every modular product is formed by a
// bit-serial interleaved (Blakley) multiplier, one multiplier bit per cycle,
// so a job costs WIDTH*(WIDTH + popcount(exp)) cycles plus CHECK and DONE.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for valid_in; operands latched on acceptance
// CHECK  | one cycle operand check (N==0, B>=N); initialise R and indices
// SQUARE | R := R*R mod N, WIDTH cycles
// MULT   | R := R*B mod N, WIDTH cycles (only when E[i]=1)
// DONE   | one cycle completion; valid_out (and error_out) pulse here
module mod_exponentiator #(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0] modulus_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] result_out,
  output logic             valid_out,
  output logic             error_out,
  output logic             busy_out
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SQUARE = 3'd2,
    S_MULT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // latched operands
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;

  // running result and modmul partial product
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_p;

  // exponent bit index and multiplier bit index (both count down)
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_j;

  // registered outputs
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_error;
  logic             r_busy;

  // modmul datapath
  logic             w_x_bit;
  logic [WIDTH-1:0] w_y;
  logic [TW-1:0]    w_t;
  logic [TW-1:0]    w_n_ext;
  logic [TW-1:0]    w_2n;
  logic [WIDTH-1:0] w_p_next;
  logic             w_last;
  logic             w_i_zero;
  logic             w_chk_err;
  logic             w_n_is_one;

  // operand check, evaluated against the latched operands during CHECK
  always_comb begin
    w_chk_err  = (r_n == '0) || (r_b >= r_n);
    w_n_is_one = (r_n == WIDTH'(1));
    w_i_zero   = (r_i == '0);
    w_last     = (r_j == '0);
  end

  // one Blakley step: t = 2P + (X[j] ? Y : 0), then reduce by 0, N or 2N
  always_comb begin
    w_x_bit = r_r[r_j];
    w_y     = (r_state == S_MULT) ? r_b : r_r;
    w_n_ext = {2'b00, r_n};
    w_2n    = {1'b0, r_n, 1'b0};
    w_t     = {1'b0, r_p, 1'b0} + (w_x_bit ? {2'b00, w_y} : {TW{1'b0}});
    if (w_t >= w_2n) begin
      w_p_next = WIDTH'(w_t - w_2n);
    end else if (w_t >= w_n_ext) begin
      w_p_next = WIDTH'(w_t - w_n_ext);
    end else begin
      w_p_next = WIDTH'(w_t);
    end
  end

  // next-state logic; the step decision is taken in the last modmul cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid_in) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_chk_err ? S_DONE : S_SQUARE;
      end
      S_SQUARE: begin
        if (w_last) begin
          if (r_e[r_i])      w_next = S_MULT;
          else if (w_i_zero) w_next = S_DONE;
          else               w_next = S_SQUARE;
        end
      end
      S_MULT: begin
        if (w_last) begin
          w_next = w_i_zero ? S_DONE : S_SQUARE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // operand latch, result register and bit indices
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_b <= '0;
      r_e <= '0;
      r_n <= '0;
      r_r <= '0;
      r_p <= '0;
      r_i <= '0;
      r_j <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_b <= base_in;
            r_e <= exp_in;
            r_n <= modulus_in;
          end
        end
        S_CHECK: begin
          // N==1 forces every residue to 0, including exp=0
          if (w_chk_err || w_n_is_one) r_r <= '0;
          else                         r_r <= WIDTH'(1);
          r_i <= IW'(WIDTH - 1);
          r_j <= IW'(WIDTH - 1);
          r_p <= '0;
        end
        S_SQUARE, S_MULT: begin
          if (w_last) begin
            r_r <= w_p_next;
            r_p <= '0;
            r_j <= IW'(WIDTH - 1);
            // moving on to the next exponent bit
            if (w_next == S_SQUARE) r_i <= r_i - IW'(1);
          end else begin
            r_p <= w_p_next;
            r_j <= r_j - IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // registered outputs, loaded from the next-state decision so they line up
  // with the DONE state itself
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= (w_next == S_DONE);
      r_error <= (r_state == S_CHECK) && w_chk_err;
      r_busy  <= (w_next != S_IDLE);
      if (w_next == S_DONE) begin
        if (r_state == S_CHECK) r_result <= '0;
        else                    r_result <= w_p_next;
      end
    end
  end

  assign result_out = r_result;
  assign valid_out  = r_valid;
  assign error_out  = r_error;
  assign busy_out   = r_busy;

endmodule

// File: tb/tb_mod_exponentiator.sv
// Bench for mod_exponentiator at WIDTH=16: directed vectors with hand-computed
// results, expectations queued at issue time and checked by a monitor.
module tb_mod_exponentiator;

  localparam int W = 16;

  logic         clk_in;
  logic         rst_in;
  logic [W-1:0] base_in;
  logic [W-1:0] exp_in;
  logic [W-1:0] modulus_in;
  logic         valid_in;
  logic [W-1:0] result_out;
  logic         valid_out;
  logic         error_out;
  logic         busy_out;

  mod_exponentiator #(.WIDTH(W)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .base_in    (base_in),
    .exp_in     (exp_in),
    .modulus_in (modulus_in),
    .valid_in   (valid_in),
    .result_out (result_out),
    .valid_out  (valid_out),
    .error_out  (error_out),
    .busy_out   (busy_out)
  );

  typedef struct {
    logic [W-1:0] res;
    bit           err;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_k = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // monitor: every valid_out must match the oldest queued expectation
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (error_out && !valid_out) begin
        total++; bad++;
        $display("FAIL err_without_valid cyc=%0d", cyc);
      end
      if (valid_out) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid cyc=%0d result=%0d", cyc, result_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          total++;
          if (result_out !== e.res) begin
            bad++;
            $display("FAIL result got=%0d want=%0d", result_out, e.res);
          end
          total++;
          if (error_out !== e.err) begin
            bad++;
            $display("FAIL error_flag got=%0b want=%0b", error_out, e.err);
          end
          total++;
          if (cyc != e.cyc) begin
            bad++;
            $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
          end
          total++;
          if (busy_out !== 1'b1) begin
            bad++;
            $display("FAIL busy_at_done got=%0b want=1", busy_out);
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b", name, got, want);
    end
  endtask

  // issue one job; returns one cycle after acceptance (cycle 1, +1 time unit)
  task automatic start(input logic [W-1:0] b, input logic [W-1:0] e,
                       input logic [W-1:0] n, input logic [W-1:0] res,
                       input bit err, input bit expect_done);
    exp_t x;
    @(posedge clk_in); #1;
    base_in    = b;
    exp_in     = e;
    modulus_in = n;
    valid_in   = 1'b1;
    last_k     = cyc;
    if (expect_done) begin
      x.res = res;
      x.err = err;
      x.cyc = err ? last_k + 2 : last_k + 2 + W * (W + $countones(e));
      sb.push_back(x);
    end
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((sb.size() != 0 || busy_out) && c < 3000) begin
      @(negedge clk_in);
      c++;
    end
    total++;
    if (c >= 3000) begin
      bad++;
      $display("FAIL timeout pending=%0d busy=%0b", sb.size(), busy_out);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk_in); #1;
    end
  endtask

  initial begin
    rst_in     = 1'b1;
    valid_in   = 1'b0;
    base_in    = '0;
    exp_in     = '0;
    modulus_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check1("rst_valid", valid_out, 1'b0);
    check1("rst_error", error_out, 1'b0);
    check1("rst_busy",  busy_out,  1'b0);
    total++;
    if (result_out !== '0) begin
      bad++;
      $display("FAIL rst_result got=%0d want=0", result_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // 4^13 mod 497 = 445 with busy window checks at cycles 0,1,306,307
    check1("busy_cycle0", busy_out, 1'b0);
    start(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 1'b1);
    @(negedge clk_in);
    check1("busy_cycle1", busy_out, 1'b1);
    wait_cyc(last_k + 306);
    @(negedge clk_in);
    check1("busy_cycle306", busy_out, 1'b1);
    @(negedge clk_in);
    check1("busy_cycle307", busy_out, 1'b0);
    wait_idle();

    // Carmichael, exp=0, N=1
    start(16'd7, 16'd560, 16'd561, 16'd1, 1'b0, 1'b1);
    wait_idle();
    start(16'd3, 16'd0, 16'd561, 16'd1, 1'b0, 1'b1);
    wait_idle();
    start(16'd0, 16'd5, 16'd1, 16'd0, 1'b0, 1'b1);
    wait_idle();

    // small RSA round trip, N=3233, e=17, d=2753
    start(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, 1'b1);
    wait_idle();
    start(16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 1'b1);
    wait_idle();

    // wide intermediate sums: (N-1)^2 = 1, (N-1)^1 = N-1, 2^10 mod 1000
    start(16'd65534, 16'd2, 16'd65535, 16'd1, 1'b0, 1'b1);
    wait_idle();
    start(16'd65534, 16'd1, 16'd65535, 16'd65534, 1'b0, 1'b1);
    wait_idle();
    start(16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, 1'b1);
    wait_idle();

    // illegal operands, then a legal job
    start(16'd5, 16'd3, 16'd0, 16'd0, 1'b1, 1'b1);
    wait_idle();
    start(16'd600, 16'd3, 16'd561, 16'd0, 1'b1, 1'b1);
    wait_idle();
    start(16'd5, 16'd3, 16'd13, 16'd8, 1'b0, 1'b1);
    wait_idle();

    // valid_in and operand changes during busy are ignored
    start(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 1'b1);
    wait_cyc(last_k + 5);
    base_in    = 16'd5;
    exp_in     = 16'd3;
    modulus_in = 16'd13;
    valid_in   = 1'b1;
    @(posedge clk_in); #1;
    valid_in   = 1'b0;
    base_in    = 16'd9;
    wait_idle();

    // reset at cycle 100 aborts silently; fresh job afterwards
    start(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 1'b0);
    wait_cyc(last_k + 100);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check1("busy_after_reset",  busy_out,  1'b0);
    check1("valid_after_reset", valid_out, 1'b0);
    repeat (400) @(negedge clk_in);
    start(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
